// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed multi-digit 7-segment scan driver
module seg7_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned DIV            = 1000,
  parameter bit          HEX            = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    pend_val_q, pend_val_d;
  logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0]    disp_val_q, disp_val_d;
  logic [DIGITS-1:0]      disp_dp_q, disp_dp_d;
  logic                   frame_done_q, frame_done_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;

  logic                   slot_end;
  logic [3:0]             nib;
  logic [DIGITS-1:0]      lz_vec;
  logic                   zero_run;
  logic                   active;

  // Active-high segment pattern {a..g} for one nibble
  function automatic logic [6:0] decode7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1110011;
      4'hA: s = HEX ? 7'b1110111 : 7'b0000000;
      4'hB: s = HEX ? 7'b0011111 : 7'b0000000;
      4'hC: s = HEX ? 7'b1001110 : 7'b0000000;
      4'hD: s = HEX ? 7'b0111101 : 7'b0000000;
      4'hE: s = HEX ? 7'b1001111 : 7'b0000000;
      default: s = HEX ? 7'b1000111 : 7'b0000000;
    endcase
    return s;
  endfunction

  // Scan counters, pending/display buffers and the frame-boundary transfer
  always_comb begin
    cnt_d        = '0;
    idx_d        = '0;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    frame_done_d = 1'b0;
    pend_val_d   = load ? value : pend_val_q;
    pend_dp_d    = load ? dp_in : pend_dp_q;
    slot_end     = (cnt_q == CNT_MAX);
    if (enable) begin
      cnt_d = slot_end ? '0 : cnt_q + CW'(1);
      idx_d = idx_q;
      if (slot_end) begin
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        if (idx_q == IDX_MAX) begin
          // Old pending contents win over a load on this same edge
          disp_val_d   = pend_val_q;
          disp_dp_d    = pend_dp_q;
          frame_done_d = 1'b1;
        end
      end
    end
  end

  // Decode of the next-state digit so the output flops line up with cnt/idx
  always_comb begin
    zero_run = 1'b1;
    lz_vec   = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (zero_run && (disp_val_d[4*i +: 4] == 4'd0)) begin
        lz_vec[i] = 1'b1;
      end else begin
        zero_run = 1'b0;
      end
    end
    nib    = disp_val_d[{idx_d, 2'b00} +: 4];
    active = (cnt_d != '0);
    an_d   = active ? (DIGITS'(1) << idx_d) : '0;
    seg_d  = (active && !(blank_lz && lz_vec[idx_d])) ? decode7(nib) : 7'b0000000;
    dp_d   = active ? disp_dp_d[idx_d] : 1'b0;
  end

  // All state and registered outputs; reset leaves every pin inactive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      frame_done_q <= 1'b0;
      an_q         <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign seg        = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dp         = dp_q ^ SEG_ACTIVE_LOW;
  assign an         = an_q ^ {DIGITS{AN_ACTIVE_LOW}};
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized and directed checks of seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int NDIV  = 4;
  localparam int FRAME = ND * NDIV;

  logic        clk = 1'b0;
  logic        rst_n, enable, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fd_a, fd_b;
  logic [3:0]  an_a, an_b;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  seg7_scan_driver #(.DIGITS(ND), .DIV(NDIV), .HEX(1'b1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a));

  seg7_scan_driver #(.DIGITS(ND), .DIV(NDIV), .HEX(1'b0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  // Reference: position within the frame plus the two buffers
  int          m_pos;
  logic [15:0] m_pend_v, m_disp_v;
  logic [3:0]  m_pend_dp, m_disp_dp;
  logic        m_blz, m_fd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_pend_v = 0; m_disp_v = 0; m_pend_dp = 0; m_disp_dp = 0; m_blz = 0; m_fd = 0;
    end else begin
      m_fd = 0;
      if (enable) begin
        if (m_pos == FRAME - 1) begin
          m_disp_v = m_pend_v; m_disp_dp = m_pend_dp; m_fd = 1; m_pos = 0;
        end else m_pos = m_pos + 1;
      end else m_pos = 0;
      if (load) begin m_pend_v = value; m_pend_dp = dp_in; end
      m_blz = blank_lz;
    end
  end

  function automatic logic [6:0] tbl(input logic [3:0] n, input bit hex);
    logic [6:0] t [16];
    t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
          7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
          7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    if (!hex && n > 9) return 7'b0;
    return t[n];
  endfunction

  function automatic bit m_active();
    return (m_pos % NDIV) != 0;
  endfunction

  function automatic logic [3:0] m_an();
    return m_active() ? 4'(1 << (m_pos / NDIV)) : 4'b0;
  endfunction

  function automatic logic [6:0] m_seg(input bit hex);
    int slot, top;
    logic [3:0] nb;
    if (!m_active()) return 7'b0;
    slot = m_pos / NDIV;
    top = 0;
    for (int i = 0; i < ND; i++) if (m_disp_v[i*4 +: 4] != 0) top = i;
    if (m_blz && slot > top) return 7'b0;
    nb = m_disp_v[slot*4 +: 4];
    return tbl(nb, hex);
  endfunction

  function automatic logic m_dp();
    return m_active() ? m_disp_dp[m_pos / NDIV] : 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the reference
  always @(negedge clk) begin
    logic [3:0] ea, eb;
    logic [6:0] sa, sb;
    logic       da, db;
    if (cmp_on) begin
      ea = m_an();  eb = ~m_an();
      sa = m_seg(1'b1); sb = ~m_seg(1'b0);
      da = m_dp();  db = ~m_dp();
      chk("an_a", 16'(an_a), 16'(ea));
      chk("seg_a", 16'(seg_a), 16'(sa));
      chk("dp_a", 16'(dp_a), 16'(da));
      chk("fd_a", 16'(fd_a), 16'(m_fd));
      chk("an_b", 16'(an_b), 16'(eb));
      chk("seg_b", 16'(seg_b), 16'(sb));
      chk("dp_b", 16'(dp_b), 16'(db));
      chk("fd_b", 16'(fd_b), 16'(m_fd));
    end
  end

  task automatic goto(input int p);
    int k = 0;
    while (m_pos != p && k < 64) begin @(negedge clk); k++; end
    if (m_pos != p) begin
      n_vec++; n_err++;
      $display("FAIL goto: position %0d required %0d", m_pos, p);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int gap;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; blank_lz = 1'b0; value = 0; dp_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_an_a", 16'(an_a), 16'h0);
    chk("rst_seg_a", 16'(seg_a), 16'h0);
    chk("rst_an_b", 16'(an_b), 16'hF);
    chk("rst_seg_b", 16'(seg_b), 16'h7F);
    chk("rst_dp_b", 16'(dp_b), 16'h1);
    rst_n = 1'b1; enable = 1'b1; cmp_on = 1'b1;
    @(negedge clk);
    chk("first_an", 16'(an_a), 16'b0001);
    chk("first_seg", 16'(seg_a), 16'(7'b1111110));
    chk("first_seg_b", 16'(seg_b), 16'(7'b0000001));
    goto(4);
    chk("guard_an", 16'(an_a), 16'h0);

    // Hex decode, scanned slot by slot
    goto(2); do_load(16'h12AF, 4'b0000);
    goto(0);
    chk("fd_pulse", 16'(fd_a), 16'h1);
    goto(1);  chk("hex_s0", 16'(seg_a), 16'(7'b1000111));
    chk("dec_s0_b", 16'(seg_b), 16'(7'b1111111));
    goto(5);  chk("hex_s1", 16'(seg_a), 16'(7'b1110111));
    goto(9);  chk("hex_s2", 16'(seg_a), 16'(7'b1101101));
    goto(13); chk("hex_s3", 16'(seg_a), 16'(7'b0110000));

    // Decimal-only instance blanks A..F
    goto(2); do_load(16'h9A00, 4'b0000);
    goto(0);
    goto(9);  chk("dec_s2_b", 16'(seg_b), 16'(7'b1111111));
    goto(13); chk("dec_s3_b", 16'(seg_b), 16'(7'b0001100));

    // Leading-zero suppression
    blank_lz = 1'b1;
    goto(2); do_load(16'h0050, 4'b0000);
    goto(0);
    goto(1);  chk("lz_s0", 16'(seg_a), 16'(7'b1111110));
    goto(5);  chk("lz_s1", 16'(seg_a), 16'(7'b1011011));
    goto(9);  chk("lz_s2", 16'(seg_a), 16'h0);
    goto(13); chk("lz_s3", 16'(seg_a), 16'h0);
    goto(2); do_load(16'h0000, 4'b1000);
    goto(0);
    goto(1);  chk("lz0_s0", 16'(seg_a), 16'(7'b1111110));
    goto(5);  chk("lz0_s1", 16'(seg_a), 16'h0);
    goto(13); chk("lz0_s3", 16'(seg_a), 16'h0);
    chk("lz0_dp3", 16'(dp_a), 16'h1);
    blank_lz = 1'b0;

    // Load on the wrap edge shows one frame later
    goto(2); do_load(16'h0003, 4'b0000);
    goto(FRAME - 1); do_load(16'h0007, 4'b0000);
    goto(1); chk("wrap_old", 16'(seg_a), 16'(7'b1111001));
    gap = 0;
    while (fd_a !== 1'b1 && gap < 40) begin @(negedge clk); gap++; end
    gap = 0;
    @(negedge clk); gap++;
    while (fd_a !== 1'b1 && gap < 40) begin @(negedge clk); gap++; end
    chk("fd_period", 16'(gap), 16'(FRAME));
    goto(1); chk("wrap_new", 16'(seg_a), 16'(7'b1110000));

    // Enable drop mid-scan restarts at slot 0
    goto(6); enable = 1'b0;
    @(negedge clk); chk("dis_an", 16'(an_a), 16'h0);
    enable = 1'b1;
    @(negedge clk); chk("reen_an", 16'(an_a), 16'b0001);

    // Asynchronous reset mid-slot
    goto(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an_a", 16'(an_a), 16'h0);
    chk("arst_seg_a", 16'(seg_a), 16'h0);
    chk("arst_an_b", 16'(an_b), 16'hF);
    chk("arst_dp_b", 16'(dp_b), 16'h1);
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      logic [15:0] v;
      v = 16'($urandom);
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 1) == 0) v[j*4 +: 4] = 4'h0;
      value    = v;
      dp_in    = 4'($urandom);
      load     = ($urandom_range(0, 3) == 0);
      blank_lz = 1'($urandom);
      enable   = ($urandom_range(0, 49) != 0);
      if (c == 800) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
